// File: rtl/irq_scheduler.sv
// rtl/irq_scheduler.sv - one-at-a-time interrupt instruction delivery to the CPU
// Optional IRQ_ROUND_ROBIN_EN selects round-robin arbitration; fixed lowest-index priority otherwise.
module irq_scheduler #(
  parameter int NUM_SRC        = 4,
  parameter int SRC_W          = 2,
  parameter int HOLDOFF_CYCLES = 1
) (
  input  logic                   proc_clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     irq_req,
  input  logic [32*NUM_SRC-1:0]  irq_inst,
  input  logic [NUM_SRC-1:0]     irq_mask,
  input  logic                   cpu_ready,
  output logic [31:0]            interrupt_instruction,
  output logic                   irq_valid,
  output logic [SRC_W-1:0]       irq_src,
  output logic [NUM_SRC-1:0]     pending,
  output logic [NUM_SRC-1:0]     overflow
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_HOLDOFF} state_t;

  localparam logic [3:0] HOLD_LOAD = 4'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  state_t             r_state;
  state_t             w_state_next;
  logic [NUM_SRC-1:0] r_req_q;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_overflow;
  logic [31:0]        r_inst;
  logic               r_valid;
  logic [SRC_W-1:0]   r_src;
  logic [3:0]         r_cnt;
  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_elig;
  logic               w_any;
  logic [SRC_W-1:0]   w_win;
  logic               w_grant;
  logic               w_xfer;
  logic [NUM_SRC-1:0] w_grant_vec;
`ifdef IRQ_ROUND_ROBIN_EN
  logic [SRC_W-1:0]   r_ptr;
  logic               w_found;
  int                 w_idx;
`endif

  assign w_edge = irq_req & ~r_req_q;
  assign w_elig = r_pending & ~irq_mask;
  assign w_any  = |w_elig;

  // Winner select: scan order depends on arbitration mode.
  always_comb begin
    w_win = '0;
`ifdef IRQ_ROUND_ROBIN_EN
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = (int'(r_ptr) + 1 + k) % NUM_SRC;
      if (!w_found && w_elig[w_idx]) begin
        w_win   = SRC_W'(w_idx);
        w_found = 1'b1;
      end
    end
`else
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_elig[k]) w_win = SRC_W'(k);
    end
`endif
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_state_next = S_PRESENT;
      S_PRESENT: if (cpu_ready) w_state_next = (HOLDOFF_CYCLES > 0) ? S_HOLDOFF : S_IDLE;
      S_HOLDOFF: if (r_cnt == 4'd0) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant     = (r_state == S_IDLE) && w_any;
    w_xfer      = (r_state == S_PRESENT) && cpu_ready;
    w_grant_vec = w_grant ? (NUM_SRC'(1) << w_win) : '0;
  end

  always_ff @(posedge proc_clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_req_q    <= '0;
      r_pending  <= '0;
      r_overflow <= '0;
      r_inst     <= '0;
      r_valid    <= 1'b0;
      r_src      <= '0;
      r_cnt      <= 4'd0;
`ifdef IRQ_ROUND_ROBIN_EN
      r_ptr      <= SRC_W'(NUM_SRC - 1);
`endif
    end else begin
      r_state    <= w_state_next;
      r_req_q    <= irq_req;
      // A fresh edge on the source being granted survives as a new request.
      r_pending  <= (r_pending & ~w_grant_vec) | w_edge;
      r_overflow <= r_overflow | (w_edge & r_pending & ~w_grant_vec);
      if (w_grant) begin
        r_inst  <= irq_inst[32*int'(w_win) +: 32];
        r_src   <= w_win;
        r_valid <= 1'b1;
`ifdef IRQ_ROUND_ROBIN_EN
        r_ptr   <= w_win;
`endif
      end else if (w_xfer) begin
        r_inst  <= '0;
        r_src   <= '0;
        r_valid <= 1'b0;
      end
      if (w_xfer) r_cnt <= HOLD_LOAD;
      else if (r_state == S_HOLDOFF && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end

  assign interrupt_instruction = r_inst;
  assign irq_valid             = r_valid;
  assign irq_src               = r_src;
  assign pending               = r_pending;
  assign overflow              = r_overflow;

endmodule

// File: tb/tb_irq_scheduler.sv
// tb/tb_irq_scheduler.sv - randomized bench for irq_scheduler against a transaction-level model
module tb_irq_scheduler;
  localparam int N    = 4;
  localparam int SW   = 2;
  localparam int HOLD = 1;

  logic            proc_clk = 1'b0;
  logic            reset;
  logic [N-1:0]    irq_req;
  logic [32*N-1:0] irq_inst;
  logic [N-1:0]    irq_mask;
  logic            cpu_ready;
  logic [31:0]     interrupt_instruction;
  logic            irq_valid;
  logic [SW-1:0]   irq_src;
  logic [N-1:0]    pending;
  logic [N-1:0]    overflow;

  irq_scheduler #(.NUM_SRC(N), .SRC_W(SW), .HOLDOFF_CYCLES(HOLD)) dut (
    .proc_clk(proc_clk), .reset(reset), .irq_req(irq_req), .irq_inst(irq_inst),
    .irq_mask(irq_mask), .cpu_ready(cpu_ready),
    .interrupt_instruction(interrupt_instruction), .irq_valid(irq_valid),
    .irq_src(irq_src), .pending(pending), .overflow(overflow)
  );

  always #5 proc_clk = ~proc_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: pending/overflow sets, the live instruction, and a cooldown
  // count of cycles that must pass before the next arbitration may happen.
  logic [N-1:0] m_pend, m_ovf, m_reqq;
  logic         m_valid;
  logic [31:0]  m_inst;
  int           m_src, m_cool, m_last;

  function automatic int pick(input logic [N-1:0] elig, input int last);
    int best, bestd, d;
    best = -1; bestd = N + 1;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) begin
`ifdef IRQ_ROUND_ROBIN_EN
        d = (i - last - 1 + 2*N) % N;
`else
        d = i;
`endif
        if (d < bestd) begin bestd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic model_step();
    int g;
    logic [N-1:0] e;
    if (reset) begin
      m_pend = '0; m_ovf = '0; m_reqq = '0; m_valid = 1'b0; m_inst = '0;
      m_src = 0; m_cool = 0; m_last = N - 1;
    end else begin
      g = -1;
      e = irq_req & ~m_reqq;
      m_reqq = irq_req;
      if (m_valid) begin
        if (cpu_ready) begin
          m_valid = 1'b0; m_inst = '0; m_src = 0; m_cool = HOLD;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else begin
        g = pick(m_pend & ~irq_mask, m_last);
        if (g >= 0) begin
          m_valid = 1'b1; m_inst = irq_inst[32*g +: 32]; m_src = g; m_last = g;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (e[i] && m_pend[i] && i != g) m_ovf[i] = 1'b1;
        m_pend[i] = (m_pend[i] && i != g) || e[i];
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] mask,
                       input logic rdy, input logic rst, input bit rnd);
    irq_req = req; irq_mask = mask; cpu_ready = rdy; reset = rst;
    if (rnd) for (int i = 0; i < N; i++) irq_inst[32*i +: 32] = $urandom;
    model_step();
    @(posedge proc_clk);
    @(negedge proc_clk);
    check_eq("valid",    32'(irq_valid),            32'(m_valid));
    check_eq("inst",     interrupt_instruction,     m_inst);
    check_eq("src",      32'(irq_src),              32'(m_src));
    check_eq("pending",  32'(pending),              32'(m_pend));
    check_eq("overflow", 32'(overflow),             32'(m_ovf));
  endtask

  logic [N-1:0] r_req, r_mask;

  initial begin
    irq_req = '0; irq_mask = '0; cpu_ready = 1'b0; reset = 1'b1; irq_inst = '0;
    @(negedge proc_clk);
    cycle('0, '0, 1'b0, 1'b1, 1'b1);
    cycle('0, '0, 1'b0, 1'b1, 1'b1);
    check_eq("rst_valid", 32'(irq_valid), 32'd0);
    check_eq("rst_pend",  32'(pending),   32'd0);

    // Single pulse on source 1.
    irq_inst = '0; irq_inst[63:32] = 32'hA000_0001;
    cycle(4'b0010, '0, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, '0, 1'b1, 1'b0, 1'b0);
    check_eq("t1_valid", 32'(irq_valid), 32'd1);
    check_eq("t1_inst",  interrupt_instruction, 32'hA000_0001);
    check_eq("t1_src",   32'(irq_src), 32'd1);
    check_eq("t1_pend",  32'(pending), 32'd0);
    cycle(4'b0000, '0, 1'b1, 1'b0, 1'b0);
    check_eq("t1_after", 32'(irq_valid), 32'd0);
    for (int k = 0; k < 3; k++) cycle('0, '0, 1'b1, 1'b0, 1'b1);

    // Simultaneous 0 and 2: 0 first, then holdoff + arbitration, then 2.
    cycle(4'b0101, '0, 1'b1, 1'b0, 1'b1);
    cycle(4'b0000, '0, 1'b1, 1'b0, 1'b1);
    check_eq("t2_first", 32'(irq_src), 32'd0);
    cycle(4'b0000, '0, 1'b1, 1'b0, 1'b1);
    check_eq("t2_gap0", 32'(irq_valid), 32'd0);
    cycle(4'b0000, '0, 1'b1, 1'b0, 1'b1);
    check_eq("t2_gap1", 32'(irq_valid), 32'd0);
    cycle(4'b0000, '0, 1'b1, 1'b0, 1'b1);
    check_eq("t2_second_v", 32'(irq_valid), 32'd1);
`ifndef IRQ_ROUND_ROBIN_EN
    check_eq("t2_second", 32'(irq_src), 32'd2);
`endif
    cycle(4'b0000, '0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle('0, '0, 1'b1, 1'b0, 1'b1);

    // Stall while presenting source 3 with changing instruction words.
    cycle(4'b1000, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cycle(4'b0000, '0, 1'b0, 1'b0, 1'b1);
    check_eq("t3_hold", 32'(irq_src), 32'd3);
    cycle(4'b0000, '0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle('0, '0, 1'b1, 1'b0, 1'b1);

    // Overflow on source 1 while masked, then delivered once after unmask.
    cycle(4'b0011, 4'b0010, 1'b1, 1'b0, 1'b1);
    cycle(4'b0000, 4'b0010, 1'b1, 1'b0, 1'b1);
    cycle(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1);
    check_eq("t4_ovf", 32'(overflow), 32'h2);
    for (int k = 0; k < 6; k++) cycle('0, '0, 1'b1, 1'b0, 1'b1);
    check_eq("t4_pend", 32'(pending), 32'd0);

    // Reset while presenting.
    cycle(4'b0100, '0, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, '0, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, '0, 1'b0, 1'b1, 1'b1);
    check_eq("t5_valid", 32'(irq_valid), 32'd0);
    check_eq("t5_ovf",   32'(overflow),  32'd0);

    r_req = '0; r_mask = '0;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) r_req[i] = ~r_req[i];
      if ($urandom_range(0, 19) == 0) r_mask = N'($urandom) & N'($urandom);
      cycle(r_req, r_mask, ($urandom_range(0, 9) < 6), ($urandom_range(0, 299) == 0), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
